seg_mux_display: RTL and testbench

//  Parametrised multi-digit, time-multiplexed 7-segment driver for the stopwatch display.

---
 rtl/seg_display_pkg.sv | 23 ++
 rtl/seg_decoder.sv | 11 +
 rtl/seg_mux_display.sv | 169 ++++++++++++++++
 tb/tb_seg_mux_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// the hex font, the all-segments-off pattern and a width helper.
package seg_display_pkg;

  // Active-high segment pattern with all segments dark.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high font, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to count 0..n-1, never less than 1 so that
  // single-entry counters still get a legal vector width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/seg_mux_display.sv
// Time-multiplexed multi-digit 7-segment driver. A prescaler divides
// each digit slot, the digit index walks all digits once per frame, and
// the displayed value is swapped only at frame boundaries so a frame is
// never drawn from two different values.
module seg_mux_display
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                            sys_clk,
  input  logic                            reset,
  input  logic                            cfg_cathode_mode,
  input  logic                            cfg_lz_blank,
  input  logic [4*NUM_DIGITS-1:0]         hex_in,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic                            load,
  output logic [6:0]                      seg_out,
  output logic                            dp_out,
  output logic [NUM_DIGITS-1:0]           dig_sel,
  output logic [clog2(NUM_DIGITS)-1:0]    digit_idx,
  output logic                            frame_tick
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int PRE_W = clog2(REFRESH_DIV);
  localparam int HEX_W = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan and content state.
  logic [PRE_W-1:0]      presc_q,      presc_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic [HEX_W-1:0]      shadow_hex_q, shadow_hex_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
  logic [HEX_W-1:0]      active_hex_q, active_hex_d;
  logic [NUM_DIGITS-1:0] active_dp_q,  active_dp_d;
  logic                  frame_pend_q;

  // Registered outputs.
  logic [6:0]            seg_q,     seg_d;
  logic                  dp_q,      dp_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [IDX_W-1:0]      idx_out_q;
  logic                  tick_q;

  logic                  slot_end;
  logic                  frame_bnd;
  logic [3:0]            act_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_vec;
  logic [6:0]            font_hi;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] sel_hi;

  assign slot_end  = (presc_q == PRE_LAST);
  assign frame_bnd = slot_end && (idx_q == IDX_LAST);

  // Next-state for prescaler, digit index, shadow and active contents.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    presc_d      = presc_q + PRE_W'(1);
    idx_d        = idx_q;
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    active_hex_d = active_hex_q;
    active_dp_d  = active_dp_q;

    if (slot_end) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      shadow_hex_d = hex_in;
      shadow_dp_d  = dp_in;
    end

    // A load on the boundary cycle itself goes straight to the display.
    if (frame_bnd) begin
      active_hex_d = load ? hex_in : shadow_hex_q;
      active_dp_d  = load ? dp_in  : shadow_dp_q;
    end
  end

  // Split the active value into per-digit nibbles.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      act_nib[k] = active_hex_q[4*k +: 4];
    end
  end

  // Leading-zero mask: digit k>0 is dark when it and every higher digit are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_vec     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (act_nib[k] == 4'h0);
      lz_vec[k]  = cfg_lz_blank && upper_zero && (k != 0);
    end
  end

  seg_decoder u_decoder (
    .nibble_i (act_nib[idx_q]),
    .seg_o    (font_hi)
  );

  // Output next-state: blanking, digit select and live polarity.
  always_comb begin
    seg_hi = lz_vec[idx_q] ? SEG_OFF : font_hi;
    sel_hi = '0;
    if (presc_q >= PRE_BLANK) begin
      sel_hi[idx_q] = 1'b1;
    end
    // Common cathode: segments active-high, digit enables active-low.
    seg_d     = cfg_cathode_mode ? seg_hi : ~seg_hi;
    dp_d      = cfg_cathode_mode ? active_dp_q[idx_q] : ~active_dp_q[idx_q];
    dig_sel_d = cfg_cathode_mode ? ~sel_hi : sel_hi;
  end

  // Scan counters and content registers.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      active_hex_q <= '0;
      active_dp_q  <= '0;
      frame_pend_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      active_hex_q <= active_hex_d;
      active_dp_q  <= active_dp_d;
      frame_pend_q <= frame_bnd;
    end
  end

  // Output registers; reset drives the "off" level of the live polarity.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      seg_q     <= cfg_cathode_mode ? SEG_OFF : ~SEG_OFF;
      dp_q      <= ~cfg_cathode_mode;
      dig_sel_q <= cfg_cathode_mode ? '1 : '0;
      idx_out_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_sel_q <= dig_sel_d;
      idx_out_q <= idx_q;
      tick_q    <= frame_pend_q;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_sel_q;
  assign digit_idx  = idx_out_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Self-checking bench for seg_mux_display (4 digits, 4-cycle slots,
// 1 blank cycle). The reference tracks elapsed cycles since reset and
// derives slot, digit and frame position arithmetically from that count.
module tb_seg_mux_display;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;
  localparam int FRAME = N * DIV;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cfg_cathode_mode;
  logic        cfg_lz_blank;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  always #5 sys_clk = ~sys_clk;

  seg_mux_display #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .cfg_cathode_mode (cfg_cathode_mode),
    .cfg_lz_blank     (cfg_lz_blank),
    .hex_in           (hex_in),
    .dp_in            (dp_in),
    .load             (load),
    .seg_out          (seg_out),
    .dp_out           (dp_out),
    .dig_sel          (dig_sel),
    .digit_idx        (digit_idx),
    .frame_tick       (frame_tick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles elapsed since reset, plus shadow and displayed values.
  int          k;
  logic [15:0] sh_hex, act_hex;
  logic [3:0]  sh_dp,  act_dp;

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare, advance the model.
  task automatic cycle(input logic rst, input logic ld, input logic [15:0] hx,
                       input logic [3:0] dpx, input string tag);
    int          pres, id;
    logic [15:0] upper;
    logic        blank;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;
    logic [1:0]  e_idx;
    logic        e_tick;

    reset = rst;
    load  = ld;
    hex_in = hx;
    dp_in  = dpx;

    if (rst) begin
      e_seg  = cfg_cathode_mode ? 7'h00 : 7'h7F;
      e_dp   = ~cfg_cathode_mode;
      e_sel  = cfg_cathode_mode ? 4'hF : 4'h0;
      e_idx  = 2'd0;
      e_tick = 1'b0;
    end else begin
      pres  = k % DIV;
      id    = (k / DIV) % N;
      upper = act_hex >> (4 * id);
      blank = cfg_lz_blank && (id > 0) && (upper == 16'h0);
      e_seg = blank ? 7'h00 : font[upper[3:0]];
      e_dp  = act_dp[id];
      e_sel = (pres < BLK) ? 4'h0 : 4'(1 << id);
      if (!cfg_cathode_mode) begin
        e_seg = ~e_seg;
        e_dp  = ~e_dp;
      end else begin
        e_sel = ~e_sel;
      end
      e_idx  = 2'(id);
      e_tick = (k > 0) && (k % FRAME == 0);
    end

    @(posedge sys_clk);
    #1;
    check($sformatf("%s seg_out k=%0d", tag, k),    16'(seg_out),    16'(e_seg));
    check($sformatf("%s dp_out k=%0d", tag, k),     16'(dp_out),     16'(e_dp));
    check($sformatf("%s dig_sel k=%0d", tag, k),    16'(dig_sel),    16'(e_sel));
    check($sformatf("%s digit_idx k=%0d", tag, k),  16'(digit_idx),  16'(e_idx));
    check($sformatf("%s frame_tick k=%0d", tag, k), 16'(frame_tick), 16'(e_tick));

    if (rst) begin
      k = 0;
      sh_hex = '0; sh_dp = '0;
      act_hex = '0; act_dp = '0;
    end else begin
      if (k % FRAME == FRAME - 1) begin
        act_hex = ld ? hx  : sh_hex;
        act_dp  = ld ? dpx : sh_dp;
      end
      if (ld) begin
        sh_hex = hx;
        sh_dp  = dpx;
      end
      k++;
    end
  endtask

  // Idle cycles with junk on the data inputs (must be ignored without load).
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), tag);
    end
  endtask

  // Advance until the model sits at the given position within a frame.
  task automatic to_phase(input int ph, input string tag);
    for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) begin
      cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), tag);
    end
  endtask

  initial begin
    k = 0;
    sh_hex = '0; sh_dp = '0; act_hex = '0; act_dp = '0;
    cfg_cathode_mode = 1'b1;
    cfg_lz_blank     = 1'b0;
    reset = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0;

    // Reset state, common cathode.
    cycle(1'b1, 1'b0, 16'h0, 4'h0, "reset");
    cycle(1'b1, 1'b0, 16'h0, 4'h0, "reset");

    // Basic scan of 12AF with dp on digit 2.
    cycle(1'b0, 1'b1, 16'h12AF, 4'b0100, "load12AF");
    run(40, "scan_cc");

    // Common anode: inverted segments and active-high digit selects.
    cfg_cathode_mode = 1'b0;
    run(20, "scan_ca");
    cfg_cathode_mode = 1'b1;

    // Leading-zero blanking.
    cfg_lz_blank = 1'b1;
    cycle(1'b0, 1'b1, 16'h0005, 4'b0000, "lz0005");
    run(36, "lz0005");
    cycle(1'b0, 1'b1, 16'h0000, 4'b1000, "lz0000");
    run(36, "lz0000");
    cycle(1'b0, 1'b1, 16'h0500, 4'b0001, "lz0500");
    run(36, "lz0500");
    cfg_lz_blank = 1'b0;

    // Mid-frame load must wait for the next frame.
    to_phase(5, "align_mid");
    cycle(1'b0, 1'b1, 16'h1111, 4'b0000, "load_mid");
    run(30, "after_mid");

    // Load on the boundary cycle bypasses the shadow.
    to_phase(FRAME - 1, "align_bnd");
    cycle(1'b0, 1'b1, 16'h2345, 4'b1010, "load_bnd");
    run(20, "after_bnd");

    // Reset in the middle of the digit-2 slot.
    to_phase(2 * DIV + 1, "align_d2");
    cycle(1'b1, 1'b0, 16'hFFFF, 4'hF, "reset_mid");
    run(20, "post_reset");

    // Randomised traffic: loads, config flips and occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(31) == 0) cfg_cathode_mode = ~cfg_cathode_mode;
      if ($urandom_range(31) == 0) cfg_lz_blank     = ~cfg_lz_blank;
      cycle(($urandom_range(99) == 0), ($urandom_range(7) == 0),
            16'($urandom >> $urandom_range(16)), 4'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
